// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage and imem.
// One outstanding request at a time; the response is a single rvalid beat.
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// buffers returned words with their PCs and presents the head to decode.
// A redirect flushes everything and marks any in-flight word for discard.
module fetch_unit #(
  parameter int               INSTR_W    = 32,
  parameter int               ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               pc_en,
  input  logic               fd_en,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  fetch_unit_if.master       imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               chng2nop,
  output logic               misalign_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;       // PC of the request currently in flight
  logic [ADDR_W-1:0]  push_pc;
  logic [INSTR_W-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  pc_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               issue, accept, push, pop;
  logic               chng_q, mis_q;

  // Issue/response decode and next state. Issue is gated by nrst so the
  // request line reads 0 while reset is held.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    issue     = nrst & pc_en & ~redirect_valid & (state == RUN) & (count < FULL_CNT);
    accept    = issue & imem.imem_ready;
    // A combinational memory answers in the accept cycle; that word
    // belongs to fetch_pc rather than the latched req_pc.
    push_pc   = (state == WAIT) ? req_pc : fetch_pc;
    case (state)
      RUN: begin
        if (accept) begin
          if (imem.imem_rvalid) push = 1'b1;
          else                  state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          push      = ~redirect_valid;
          state_nxt = RUN;
        end else if (redirect_valid) begin
          state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (imem.imem_rvalid) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & fd_en & ~stall & ~redirect_valid;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= RUN;
    else       state <= state_nxt;
  end

  // Program counter and in-flight request PC; redirect wins over accept.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (accept) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= imem.imem_rdata;
      pc_q[wr_ptr]   <= push_pc;
    end
  end

  // Squash pulse follows every redirect cycle; misalignment is sticky.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chng_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      chng_q <= redirect_valid;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) mis_q <= 1'b1;
    end
  end

  assign imem.imem_req  = issue;
  assign imem.imem_addr = fetch_pc;
  assign instr_out      = instr_valid ? data_q[rd_ptr] : '0;
  assign pc_out         = instr_valid ? pc_q[rd_ptr]   : '0;
  assign chng2nop       = chng_q;
  assign misalign_err   = mis_q;

endmodule
